// File: rtl/seg7_bcd_sched.sv
// seg7_bcd_sched: one shift-add-3 binary-to-BCD converter shared round-robin
// among NREQ requesters. A granted operand is converted one bit per clock and
// the packed BCD digits plus the winner's index are presented to the digit bus.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   req       in   level request per requester
//   bin_in    in   operands, requester i uses bits [i*W +: W]
//   gnt       out  one-hot 1-cycle pulse when requester i's operand is latched
//   busy      out  conversion in progress
//   done      out  1-cycle pulse when bcd_out/src_id are updated
//   src_id    out  requester index of the result on bcd_out
//   bcd_out   out  packed BCD digits, ones in [3:0]
module seg7_bcd_sched #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*W-1:0]     bin_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            src_id,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int unsigned BW = DIGITS * 4;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_shreg;
    logic [BW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic [2:0]      r_src;
    logic [BW-1:0]   r_bcd;

    logic            w_found;
    logic [2:0]      w_win;
    logic [W-1:0]    w_op;
    logic            w_grant;
    logic [NREQ-1:0] w_gnt_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [BW-1:0]   w_acc_adj;

    // Round-robin arbiter: search starts just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!w_found && req[i] && (i == (32'(r_ptr) + k) % NREQ)) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                end
            end
        end
    end

    // Operand slice of the current winner.
    always_comb begin
        w_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (i == 32'(w_win)) begin
                w_op = bin_in[i*W +: W];
            end
        end
    end

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        w_acc_adj = r_acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_acc[d*4 +: 4] >= 4'd5) begin
                w_acc_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_cnt == CW'(W - 1)) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake outputs.
    always_comb begin
        w_grant    = 1'b0;
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant    = w_found;
                w_busy_nxt = w_found;
            end
            S_SHIFT:  w_busy_nxt = 1'b1;
            S_FINISH: w_done_nxt = 1'b1;
            default:  w_busy_nxt = 1'b0;
        endcase
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_gnt_nxt[i] = w_grant && (i == 32'(w_win));
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ptr   <= 3'(NREQ - 1);
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_src   <= 3'd0;
            r_bcd   <= '0;
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_grant) begin
                r_shreg <= w_op;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ptr   <= w_win;
            end
            if (r_state == S_SHIFT) begin
                // Top digit cannot carry out when 10**DIGITS > 2**W-1.
                r_acc   <= BW'({w_acc_adj, r_shreg[W-1]});
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt + CW'(1);
            end
            if (r_state == S_FINISH) begin
                r_bcd <= r_acc;
                r_src <= r_ptr;
            end
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign src_id  = r_src;
    assign bcd_out = r_bcd;

endmodule

// File: tb/tb_seg7_bcd_sched.sv
// Testbench for seg7_bcd_sched (NREQ=2, W=8, DIGITS=3). Stimulus pushes the
// expected grants and results into queues; a monitor pops and compares them
// whenever the DUT pulses gnt or done.
module tb_seg7_bcd_sched;

    logic        CLOCK_50;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] bin_in;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic [2:0]  src_id;
    logic [11:0] bcd_out;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    int          exp_gnt[$];
    int          exp_src[$];
    logic [11:0] exp_bcd[$];

    seg7_bcd_sched #(.NREQ(2), .W(8), .DIGITS(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .req      (req),
        .bin_in   (bin_in),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .src_id   (src_id),
        .bcd_out  (bcd_out)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: compares every gnt and done pulse against the scoreboard.
    int gnt_cycle = 0;
    bit in_flight = 1'b0;
    always @(negedge CLOCK_50) begin
        if (rst) begin
            in_flight = 1'b0;
        end else begin
            if (gnt != 2'b00) begin
                chk("gnt_while_busy", 32'(in_flight), 32'd0);
                chk("busy_at_gnt", 32'(busy), 32'd1);
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    chk("gnt_onehot", 32'(gnt), 32'(1) << exp_gnt.pop_front());
                end
                in_flight = 1'b1;
                gnt_cycle = cycle;
            end
            if (done) begin
                if (exp_bcd.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    chk("bcd_out", 32'(bcd_out), 32'(exp_bcd.pop_front()));
                    chk("src_id", 32'(src_id), 32'(exp_src.pop_front()));
                    chk("latency", 32'(cycle - gnt_cycle), 32'd9);
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
                in_flight = 1'b0;
            end
        end
    end

    task automatic wait_gnt();
        int n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (gnt == 2'b00 && n < 40);
        if (gnt == 2'b00) chk("gnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while ((exp_gnt.size() != 0 || exp_bcd.size() != 0 || busy) && n < 100);
        if (exp_gnt.size() != 0 || exp_bcd.size() != 0 || busy) begin
            chk("idle_timeout", 32'd1, 32'd0);
            exp_gnt.delete();
            exp_src.delete();
            exp_bcd.delete();
        end
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
    endtask

    task automatic convert(input int id, input logic [7:0] v, input logic [11:0] e);
        bin_in[id*8 +: 8] = v;
        exp_gnt.push_back(id);
        exp_src.push_back(id);
        exp_bcd.push_back(e);
        req[id] = 1'b1;
        wait_gnt();
        req[id] = 1'b0;
        wait_idle();
    endtask

    logic [7:0]  bnd_val [4] = '{8'd0, 8'd9, 8'd99, 8'd100};
    logic [11:0] bnd_exp [4] = '{12'h000, 12'h009, 12'h099, 12'h100};

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        bin_in = '0;
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
        @(negedge CLOCK_50);

        // Reset state.
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h000);
        chk("rst_src", 32'(src_id), 32'd0);

        // Full-scale operand.
        convert(0, 8'd255, 12'h255);

        // Both requesters held: grants alternate starting from 0 after reset.
        do_reset();
        @(negedge CLOCK_50);
        bin_in = {8'd128, 8'd7};
        exp_gnt.push_back(0); exp_src.push_back(0); exp_bcd.push_back(12'h007);
        exp_gnt.push_back(1); exp_src.push_back(1); exp_bcd.push_back(12'h128);
        exp_gnt.push_back(0); exp_src.push_back(0); exp_bcd.push_back(12'h007);
        req = 2'b11;
        repeat (3) wait_gnt();
        req = 2'b00;
        wait_idle();

        // Digit boundaries.
        for (int i = 0; i < 4; i++) convert(0, bnd_val[i], bnd_exp[i]);

        // Reset during the fourth shift cycle aborts the conversion.
        bin_in[7:0] = 8'd200;
        exp_gnt.push_back(0);
        req[0] = 1'b1;
        wait_gnt();
        req[0] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'h000);
        chk("abort_src", 32'(src_id), 32'd0);
        @(negedge CLOCK_50);
        rst = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("abort_no_done_bcd", 32'(bcd_out), 32'h000);
        convert(0, 8'd42, 12'h042);

        // Late request and operand change while busy.
        bin_in[7:0] = 8'd123;
        exp_gnt.push_back(0); exp_src.push_back(0); exp_bcd.push_back(12'h123);
        exp_gnt.push_back(1); exp_src.push_back(1); exp_bcd.push_back(12'h056);
        req[0] = 1'b1;
        wait_gnt();
        req[0] = 1'b0;
        req[1] = 1'b1;
        bin_in[15:8] = 8'd56;
        @(negedge CLOCK_50);
        bin_in[7:0] = 8'd99;
        wait_gnt();
        req[1] = 1'b0;
        wait_idle();

        // Results hold between done pulses.
        repeat (3) @(negedge CLOCK_50);
        chk("hold_bcd", 32'(bcd_out), 32'h056);
        chk("hold_src", 32'(src_id), 32'd1);
        chk("queues_empty", 32'(exp_gnt.size() + exp_bcd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
